sipo_stream: RTL
================

# sipo_stream

Parametrised serial-in/parallel-out packer with valid/ready handshakes on both sides. It gathers DATA_IN_W-bit beats into DATA_OUT_W-bit words in a selectable bit order, and a last-beat marker can close a word early as a partial word. A one-word output register plus the assembly register give double buffering, so input streams at one beat per cycle while downstream is ready. The block sits between the bit-serial decoder datapath and byte/word-wide consumers in the Viterbi decoder.

## Interface
- DATA_IN_W, 1, beat width in bits.
- DATA_OUT_W, 8, word width in bits. Must be a multiple of DATA_IN_W. N = DATA_OUT_W/DATA_IN_W, with N ≥ 2.
- MSB_FIRST, 1, packing order. 1: first beat lands in the top slot. 0: first beat lands in the bottom slot.
- CNT_W, derived = $clog2(N+1), width of o_count.

Ports:
- i_clk  in  1  clock. Single clock domain.
- i_rst_n  in  1  synchronous, active-low reset.
- i_clear  in  1  synchronous flush. Discards the partial word and the output word.
- i_valid  in  1  input beat valid.
- i_data  in  DATA_IN_W  input beat.
- i_last  in  1  beat closes the current word. Sampled only on an accepted beat.
- o_ready  out  1  block can accept a beat.
- o_valid  out  1  output word valid.
- o_data  out  DATA_OUT_W  packed word.
- o_count  out  CNT_W  number of valid beats in o_data, range 1..N.
- o_last  out  1  word was closed by i_last.
- i_ready  in  1  downstream accepts the word.
- o_done  out  1  word handed off. Equals o_valid & i_ready.

## Operation
- Beat accepted when i_valid & o_ready. Word consumed when o_valid & i_ready.
- Assembly register asm, beat counter cnt (0..N-1), FSM with two states: FILL and HOLD.
- FILL, beat accepted: the beat is written into slot cnt.
  - MSB_FIRST=1: slot k = bits [DATA_OUT_W-1-k*DATA_IN_W -: DATA_IN_W].
  - MSB_FIRST=0: slot k = bits [k*DATA_IN_W +: DATA_IN_W].
- A word closes when the accepted beat has cnt==N-1 or i_last=1.
- On close, the output register is free when o_valid=0 or it is consumed in the same cycle. Then:
  - o_data ← word with unfilled slots zero.
  - o_count ← cnt+1, o_last ← i_last, o_valid ← 1.
  - asm ← 0, cnt ← 0, state stays FILL.
- On close with the output register occupied and not consumed: the word is kept in asm with its count and last flag, and state ← HOLD.
- HOLD: o_ready=0. On the cycle the output word is consumed, the held word moves to the output register, asm/cnt are cleared, and state ← FILL.
- Output register not refilled in a cycle: if consumed, o_valid ← 0. o_data, o_count and o_last hold their values.
- i_clear (priority below reset, above everything else) has the same effect as reset. Beats presented in that cycle are dropped.
- i_last on the N-th beat: full word with o_count=N and o_last=1.
- i_valid with o_ready=0: beat is not accepted. The source must hold it.

## Timing
- Reset values (i_rst_n=0 at an edge): o_valid=0, o_data=0, o_count=0, o_last=0, cnt=0, asm=0, state=FILL.
- o_ready = i_rst_n & (state==FILL). It is combinational and 0 while reset is held.
- Latency: o_valid rises on the edge that accepts the closing beat, i.e. visible 1 cycle after the closing beat is presented.
- Throughput: 1 beat/cycle sustained with i_ready held 1. No bubbles between words.
- Backpressure: with i_ready=0, up to 2N beats are absorbed. o_ready falls in the cycle after the 2N-th accepted beat.
- Leaving HOLD: o_ready returns 1 the cycle after the consuming handshake, which costs 1 bubble on the input.
- o_done is combinational and lasts one cycle per consumed word.
- Reset or clear mid-word: no partial word is ever emitted. The next word starts at slot 0.

## Test plan
- MSB_FIRST=1, 1→8, i_ready=1: beats 1,0,1,1,0,0,1,0 -> o_data=8'hB2, o_count=8, o_last=0, o_valid for 1 cycle, o_done pulses with it.
- MSB_FIRST=0, same beats -> o_data=8'h4D, o_count=8. Second build, DATA_IN_W=2, MSB_FIRST=1, beats 2'b11,2'b00,2'b10,2'b01 -> 8'hC9.
- Partial word, 1→8, MSB_FIRST=1: beats 1,1,1 with i_last on the third -> o_data=8'hE0, o_count=3, o_last=1. The next 8 beats form a fresh full word.
- Backpressure: i_ready=0, i_valid=1 continuously with 16 beats forming 8'hA5 then 8'h3C -> o_ready drops after the 16th beat and o_valid shows 8'hA5. Raising i_ready -> 8'hA5 consumed, 8'h3C in the next cycle, no loss or reorder, o_ready back to 1.
- Reset mid-word: 5 beats, then i_rst_n=0 for 2 cycles -> all outputs at reset values and o_ready=0 during reset. Then 8 ones -> 8'hFF, o_count=8, no residue from the 5 beats.
- i_clear while in HOLD with a valid output word -> o_valid=0 next cycle, state FILL, o_ready=1, both words discarded.

Source files
------------

// File: rtl/sipo_stream.sv
`default_nettype none
// ============================================================================
// Module   : sipo_stream
// Purpose  : Serial-in/parallel-out packer, valid/ready on both sides,
//            double-buffered (assembly + output register), early close on last.
// Revision : 1.0
// ============================================================================
module sipo_stream #(
   parameter int DATA_IN_W  = 1,
   parameter int DATA_OUT_W = 8,
   parameter bit MSB_FIRST  = 1'b1,
   parameter int CNT_W      = $clog2(DATA_OUT_W / DATA_IN_W + 1)
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_clear,
   input  logic                  i_valid,
   input  logic [DATA_IN_W-1:0]  i_data,
   input  logic                  i_last,
   output logic                  o_ready,
   output logic                  o_valid,
   output logic [DATA_OUT_W-1:0] o_data,
   output logic [CNT_W-1:0]      o_count,
   output logic                  o_last,
   input  logic                  i_ready,
   output logic                  o_done
);

   localparam int c_N = DATA_OUT_W / DATA_IN_W;

   typedef enum logic [0:0] {
      FILL = 1'b0,
      HOLD = 1'b1
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [DATA_OUT_W-1:0] r_asm;
   logic [CNT_W-1:0]      r_cnt;
   logic                  r_hold_last;
   logic [DATA_OUT_W-1:0] r_out_data;
   logic [CNT_W-1:0]      r_out_cnt;
   logic                  r_out_last;
   logic                  r_out_valid;

   logic                  w_accept;
   logic                  w_consume;
   logic                  w_close;
   logic                  w_out_free;
   logic [DATA_OUT_W-1:0] w_word;
   logic                  w_load_out;
   logic [DATA_OUT_W-1:0] w_load_data;
   logic [CNT_W-1:0]      w_load_cnt;
   logic                  w_load_last;
   logic                  w_asm_clr;
   logic                  w_asm_upd;
   logic                  w_hold_save;

   assign o_ready    = i_rst_n & (r_state == FILL);
   assign w_accept   = i_valid & o_ready;
   assign w_consume  = r_out_valid & i_ready;
   assign w_out_free = ~r_out_valid | i_ready;
   assign w_close    = w_accept & ((r_cnt == CNT_W'(c_N - 1)) | i_last);

   // Current partial word with the incoming beat dropped into slot r_cnt.
   always_comb begin
      w_word = r_asm;
      for (int k = 0; k < c_N; k++) begin
         if (r_cnt == CNT_W'(k))
            w_word[(MSB_FIRST ? (c_N - 1 - k) : k) * DATA_IN_W +: DATA_IN_W] = i_data;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_load_out  = 1'b0;
      w_load_data = w_word;
      w_load_cnt  = r_cnt + CNT_W'(1);
      w_load_last = i_last;
      w_asm_clr   = 1'b0;
      w_asm_upd   = 1'b0;
      w_hold_save = 1'b0;
      case (r_state)
         FILL: begin
            if (w_close) begin
               if (w_out_free) begin
                  w_load_out = 1'b1;
                  w_asm_clr  = 1'b1;
               end else begin
                  w_hold_save = 1'b1;
                  w_state_nxt = HOLD;
               end
            end else if (w_accept) begin
               w_asm_upd = 1'b1;
            end
         end
         HOLD: begin
            // In HOLD r_cnt already carries the beat count of the held word.
            if (w_consume) begin
               w_load_out  = 1'b1;
               w_load_data = r_asm;
               w_load_cnt  = r_cnt;
               w_load_last = r_hold_last;
               w_asm_clr   = 1'b1;
               w_state_nxt = FILL;
            end
         end
         default: w_state_nxt = FILL;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n || i_clear) begin
         r_state     <= FILL;
         r_asm       <= '0;
         r_cnt       <= '0;
         r_hold_last <= 1'b0;
         r_out_data  <= '0;
         r_out_cnt   <= '0;
         r_out_last  <= 1'b0;
         r_out_valid <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_asm_clr) begin
            r_asm <= '0;
            r_cnt <= '0;
         end else if (w_hold_save) begin
            r_asm       <= w_word;
            r_cnt       <= r_cnt + CNT_W'(1);
            r_hold_last <= i_last;
         end else if (w_asm_upd) begin
            r_asm <= w_word;
            r_cnt <= r_cnt + CNT_W'(1);
         end
         if (w_load_out) begin
            r_out_data  <= w_load_data;
            r_out_cnt   <= w_load_cnt;
            r_out_last  <= w_load_last;
            r_out_valid <= 1'b1;
         end else if (w_consume) begin
            r_out_valid <= 1'b0;
         end
      end
   end

   assign o_valid = r_out_valid;
   assign o_data  = r_out_data;
   assign o_count = r_out_cnt;
   assign o_last  = r_out_last;
   assign o_done  = w_consume;

endmodule
`default_nettype wire
